// File: rtl/param_universal_shift_reg.sv
// WIDTH-bit universal shift register with eight modes and a shift-frame counter.
// Serves as the serial<->parallel converter for the serial link and test-pattern blocks.
module param_universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHL   = 3'b001,
        M_SHR   = 3'b010,
        M_LOAD  = 3'b011,
        M_ROL   = 3'b100,
        M_ROR   = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q, q_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir, dir_nxt;
    logic             done_nxt;
    logic             shift;

    always_comb begin
        q_nxt    = q;
        dir_nxt  = dir;
        cnt_nxt  = bit_cnt;
        done_nxt = 1'b0;
        shift    = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                M_SHL:   begin q_nxt = {q[WIDTH-2:0], s_in};     dir_nxt = 1'b0; shift = 1'b1; end
                M_SHR:   begin q_nxt = {s_in, q[WIDTH-1:1]};     dir_nxt = 1'b1; shift = 1'b1; end
                M_LOAD:  begin q_nxt = p_in;                     cnt_nxt = '0; end
                M_ROL:   begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; dir_nxt = 1'b0; shift = 1'b1; end
                M_ROR:   begin q_nxt = {q[0], q[WIDTH-1:1]};     dir_nxt = 1'b1; shift = 1'b1; end
                M_ASR:   begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; dir_nxt = 1'b1; shift = 1'b1; end
                M_CLEAR: begin q_nxt = '0;                       cnt_nxt = '0; end
                default: ;
            endcase
            // Counter tracks shift events regardless of direction; wrap emits the pulse.
            if (shift) begin
                if (bit_cnt == LAST_CNT) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= RESET_VAL;
            dir        <= 1'b0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            q          <= q_nxt;
            dir        <= dir_nxt;
            bit_cnt    <= cnt_nxt;
            frame_done <= done_nxt;
        end
    end

    // dir is only rewritten by shifting modes, so the output bit stays put across HOLD/LOAD.
    assign serial_out   = dir ? q[0] : q[WIDTH-1];
    assign parallel_out = q;

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Directed testbench for param_universal_shift_reg: an 8-bit instance for the
// mode/frame scenarios and a 5-bit instance with a non-zero reset value.
module tb_param_universal_shift_reg;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [2:0] mode  = M_HOLD;
  logic       s_in  = 1'b0;
  logic [7:0] p_in  = 8'h00;
  logic       serial_out;
  logic [7:0] pout;
  logic [3:0] bit_cnt;
  logic       frame_done;

  logic       rst2_n = 1'b0;
  logic       en2    = 1'b0;
  logic [2:0] mode2  = M_HOLD;
  logic       s_in2  = 1'b0;
  logic [4:0] p_in2  = 5'h00;
  logic       serial_out2;
  logic [4:0] pout2;
  logic [2:0] bit_cnt2;
  logic       frame_done2;

  param_universal_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s_in(s_in), .p_in(p_in),
    .serial_out(serial_out), .parallel_out(pout), .bit_cnt(bit_cnt), .frame_done(frame_done)
  );

  param_universal_shift_reg #(.WIDTH(5), .RESET_VAL(5'b10101)) dut5 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .s_in(s_in2), .p_in(p_in2),
    .serial_out(serial_out2), .parallel_out(pout2), .bit_cnt(bit_cnt2), .frame_done(frame_done2)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic si, input logic [7:0] pi);
    en   = 1'b1;
    mode = m;
    s_in = si;
    p_in = pi;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    rst_n = 1'b1;
    drive(M_LOAD, 1'b0, 8'h5A);
    compared++;
    if (pout !== 8'h5A) begin mismatched++; $display("FAIL reset_preload: got %h want %h", pout, 8'h5A); end
    #2;
    rst_n = 1'b0;
    #2;
    compared++;
    if (pout !== 8'h00) begin mismatched++; $display("FAIL reset_async_q: got %h want %h", pout, 8'h00); end
    compared++;
    if (bit_cnt !== 4'd0) begin mismatched++; $display("FAIL reset_async_cnt: got %0d want 0", bit_cnt); end
    compared++;
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_async_done: got %b want 0", frame_done); end
    tick();
    rst_n = 1'b1;
    drive(M_HOLD, 1'b1, 8'hFF);
    drive(M_HOLD, 1'b1, 8'hFF);
    compared++;
    if (pout !== 8'h00) begin mismatched++; $display("FAIL reset_release_hold: got %h want %h", pout, 8'h00); end
  endtask

  task automatic test_modes();
    drive(M_LOAD, 1'b0, 8'hA5);
    compared++;
    if (pout !== 8'hA5) begin mismatched++; $display("FAIL load: got %h want %h", pout, 8'hA5); end
    drive(M_ROL, 1'b0, 8'h00);
    compared++;
    if (pout !== 8'h4B) begin mismatched++; $display("FAIL rol: got %h want %h", pout, 8'h4B); end
    compared++;
    if (serial_out !== 1'b0) begin mismatched++; $display("FAIL rol_serial: got %b want 0", serial_out); end
    drive(M_ROR, 1'b0, 8'h00);
    compared++;
    if (pout !== 8'hA5) begin mismatched++; $display("FAIL ror: got %h want %h", pout, 8'hA5); end
    compared++;
    if (serial_out !== 1'b1) begin mismatched++; $display("FAIL ror_serial: got %b want 1", serial_out); end
    drive(M_SHR, 1'b0, 8'h00);
    compared++;
    if (pout !== 8'h52) begin mismatched++; $display("FAIL shr: got %h want %h", pout, 8'h52); end
    compared++;
    if (serial_out !== 1'b0) begin mismatched++; $display("FAIL shr_serial: got %b want 0", serial_out); end
    // LOAD must not touch dir: still reading bit 0 of 0x80.
    drive(M_LOAD, 1'b0, 8'h80);
    compared++;
    if (serial_out !== 1'b0) begin mismatched++; $display("FAIL load_keeps_dir: got %b want 0", serial_out); end
    drive(M_SHL, 1'b1, 8'h00);
    compared++;
    if (pout !== 8'h01) begin mismatched++; $display("FAIL shl: got %h want %h", pout, 8'h01); end
    compared++;
    if (serial_out !== 1'b0) begin mismatched++; $display("FAIL shl_serial: got %b want 0", serial_out); end
    drive(M_LOAD, 1'b0, 8'h90);
    drive(M_ASR, 1'b0, 8'h00);
    compared++;
    if (pout !== 8'hC8) begin mismatched++; $display("FAIL asr1: got %h want %h", pout, 8'hC8); end
    drive(M_ASR, 1'b1, 8'h00);
    compared++;
    if (pout !== 8'hE4) begin mismatched++; $display("FAIL asr2: got %h want %h", pout, 8'hE4); end
    drive(M_HOLD, 1'b1, 8'hFF);
    compared++;
    if (pout !== 8'hE4) begin mismatched++; $display("FAIL hold: got %h want %h", pout, 8'hE4); end
    drive(M_CLEAR, 1'b1, 8'hFF);
    compared++;
    if (pout !== 8'h00) begin mismatched++; $display("FAIL clear: got %h want %h", pout, 8'h00); end
  endtask

  task automatic test_shl_frame();
    logic [7:0] pat;
    logic [3:0] exp_cnt;
    logic       exp_done;
    pat = 8'b1011_0010;
    drive(M_CLEAR, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      drive(M_SHL, pat[7-i], 8'h00);
      exp_cnt  = (i == 7) ? 4'd0 : 4'(i + 1);
      exp_done = (i == 7);
      compared++;
      if (bit_cnt !== exp_cnt) begin mismatched++; $display("FAIL frame_cnt[%0d]: got %0d want %0d", i, bit_cnt, exp_cnt); end
      compared++;
      if (frame_done !== exp_done) begin mismatched++; $display("FAIL frame_done[%0d]: got %b want %b", i, frame_done, exp_done); end
    end
    compared++;
    if (pout !== 8'hB2) begin mismatched++; $display("FAIL frame_data: got %h want %h", pout, 8'hB2); end
    drive(M_SHL, 1'b0, 8'h00);
    compared++;
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL frame_pulse_width: got %b want 0", frame_done); end
  endtask

  task automatic test_enable();
    int pulses;
    drive(M_CLEAR, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(M_SHL, 1'b1, 8'h00);
    compared++;
    if (bit_cnt !== 4'd3) begin mismatched++; $display("FAIL en_pre_cnt: got %0d want 3", bit_cnt); end
    en = 1'b0; mode = M_SHL; s_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (pout !== 8'h07) begin mismatched++; $display("FAIL en_freeze_q: got %h want %h", pout, 8'h07); end
    compared++;
    if (bit_cnt !== 4'd3) begin mismatched++; $display("FAIL en_freeze_cnt: got %0d want 3", bit_cnt); end
    drive(M_LOAD, 1'b0, 8'h0F);
    compared++;
    if (bit_cnt !== 4'd0 || frame_done !== 1'b0) begin
      mismatched++; $display("FAIL load_restart: got cnt=%0d done=%b want cnt=0 done=0", bit_cnt, frame_done);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(M_SHL, 1'b0, 8'h00);
      if (frame_done === 1'b1) pulses++;
    end
    compared++;
    if (pulses !== 1 || frame_done !== 1'b1) begin
      mismatched++; $display("FAIL load_then_frame: got pulses=%0d last=%b want 1/1", pulses, frame_done);
    end
    // A pending pulse clears even with en low.
    en = 1'b0;
    tick();
    compared++;
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL en_low_clears_done: got %b want 0", frame_done); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    logic [7:0]  exp_q;
    logic        exp_done;
    pat = 16'hC3A5;
    drive(M_LOAD, 1'b0, 8'h00);
    exp_q = 8'h00;
    for (int i = 0; i < 16; i++) begin
      drive(M_SHR, pat[i], 8'h00);
      exp_q    = {pat[i], exp_q[7:1]};
      exp_done = (i == 7) || (i == 15);
      compared++;
      if (frame_done !== exp_done) begin mismatched++; $display("FAIL b2b_done[%0d]: got %b want %b", i, frame_done, exp_done); end
      compared++;
      if (serial_out !== exp_q[0]) begin mismatched++; $display("FAIL b2b_serial[%0d]: got %b want %b", i, serial_out, exp_q[0]); end
    end
    compared++;
    if (pout !== 8'hC3) begin mismatched++; $display("FAIL b2b_data: got %h want %h", pout, 8'hC3); end
    // Mixed directions in one frame still count eight shifts.
    drive(M_CLEAR, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(M_SHL, 1'b1, 8'h00);
    compared++;
    if (bit_cnt !== 4'd4) begin mismatched++; $display("FAIL mixed_cnt: got %0d want 4", bit_cnt); end
    for (int i = 0; i < 4; i++) drive(M_ROR, 1'b0, 8'h00);
    compared++;
    if (frame_done !== 1'b1 || bit_cnt !== 4'd0) begin
      mismatched++; $display("FAIL mixed_done: got done=%b cnt=%0d want 1/0", frame_done, bit_cnt);
    end
    compared++;
    if (pout !== 8'hF0) begin mismatched++; $display("FAIL mixed_data: got %h want %h", pout, 8'hF0); end
  endtask

  task automatic test_reset_mid_frame();
    drive(M_CLEAR, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) drive(M_SHL, 1'b1, 8'h00);
    rst_n = 1'b0;
    #1;
    compared++;
    if (frame_done !== 1'b0 || bit_cnt !== 4'd0 || pout !== 8'h00) begin
      mismatched++; $display("FAIL reset_mid_frame: got done=%b cnt=%0d q=%h want 0/0/00", frame_done, bit_cnt, pout);
    end
    tick();
    rst_n = 1'b1;
    drive(M_SHL, 1'b1, 8'h00);
    drive(M_SHL, 1'b1, 8'h00);
    compared++;
    if (bit_cnt !== 4'd2) begin mismatched++; $display("FAIL reset_restart_cnt: got %0d want 2", bit_cnt); end
  endtask

  task automatic test_width5();
    logic [4:0] exp_q;
    int         pulses;
    #1;
    compared++;
    if (pout2 !== 5'h15) begin mismatched++; $display("FAIL w5_reset: got %h want %h", pout2, 5'h15); end
    tick();
    rst2_n = 1'b1;
    en2    = 1'b1;
    mode2  = M_ROL;
    exp_q  = 5'h15;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_q = {exp_q[3:0], exp_q[4]};
      if (frame_done2 === 1'b1) pulses++;
      compared++;
      if (pout2 !== exp_q) begin mismatched++; $display("FAIL w5_rol[%0d]: got %h want %h", i, pout2, exp_q); end
    end
    compared++;
    if (pout2 !== 5'h15 || frame_done2 !== 1'b1 || pulses !== 1) begin
      mismatched++; $display("FAIL w5_frame: got q=%h done=%b pulses=%0d want 15/1/1", pout2, frame_done2, pulses);
    end
    en2 = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_modes();
    test_shl_frame();
    test_enable();
    test_back_to_back();
    test_reset_mid_frame();
    test_width5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
